// File: rtl/addr_calc_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : addr_calc_sched_if
// Brief    : Requester, operand and result handshake bundle for addr_calc_sched.
// Revision : 1.0  initial release
// ============================================================================
interface addr_calc_sched_if #(
  parameter int AW = 8,
  parameter int CW = 16
);
  logic          req0_valid;
  logic [AW-1:0] req0_ptr;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_ptr;
  logic          req1_ready;
  logic [AW-1:0] address;
  logic [AW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_src;
  logic          busy;

  modport master (
    output req0_valid, req0_ptr, req1_valid, req1_ptr, address, b, out_ready,
    input  req0_ready, req1_ready, out_valid, out_count, out_src, busy
  );

  modport slave (
    input  req0_valid, req0_ptr, req1_valid, req1_ptr, address, b, out_ready,
    output req0_ready, req1_ready, out_valid, out_count, out_src, busy
  );
endinterface
`default_nettype wire

// File: rtl/addr_calc_sched.sv
`default_nettype none
// ============================================================================
// Module   : addr_calc_sched
// Brief    : Two-requester arbitrated, two-stage count = address - BASE + ptr + b.
//            Define ADDR_CALC_FIXPRIO_EN for fixed priority (req1 wins).
// Revision : 1.0  initial release
// ============================================================================
module addr_calc_sched #(
  parameter int            AW   = 8,
  parameter int            CW   = 16,
  parameter logic [AW-1:0] BASE = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  addr_calc_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONE  = 2'd1;
  localparam logic [1:0] S_TWO  = 2'd2;

  localparam logic [CW-AW-1:0] c_pad  = '0;
  localparam logic [CW-1:0]    c_base = {c_pad, BASE};
`ifdef ADDR_CALC_FIXPRIO_EN
  localparam logic c_fixprio = 1'b1;
`else
  localparam logic c_fixprio = 1'b0;
`endif

  logic [1:0]    r_state;
  logic          r_last_grant;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_b;
  logic          r_src;
  logic [CW-1:0] r_p;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;

  assign w_idle   = (r_state == S_IDLE);
  // req1 wins on contention only when req0 was served last (or always in fixed priority)
  assign w_gnt1   = bus.req1_valid & (c_fixprio | ~bus.req0_valid | ~r_last_grant);
  assign w_gnt0   = bus.req0_valid & ~w_gnt1;
  assign w_accept = w_idle & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready = w_idle & w_gnt0;
  assign bus.req1_ready = w_idle & w_gnt1;
  assign bus.out_valid  = (r_state == S_TWO);
  assign bus.out_count  = r_p + {c_pad, r_b};
  assign bus.out_src    = r_src;
  assign bus.busy       = ~w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_ptr        <= '0;
      r_addr       <= '0;
      r_b          <= '0;
      r_src        <= 1'b0;
      r_p          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ptr        <= w_gnt1 ? bus.req1_ptr : bus.req0_ptr;
            r_addr       <= bus.address;
            r_b          <= bus.b;
            r_src        <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_state      <= S_ONE;
          end
        end
        S_ONE: begin
          r_p     <= {c_pad, r_addr} - c_base + {c_pad, r_ptr};
          r_state <= S_TWO;
        end
        S_TWO: begin
          // r_p/r_b/r_src are untouched here, so the result holds under backpressure
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_calc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_calc_sched
// Brief    : Directed self-checking bench for addr_calc_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_addr_calc_sched;

`ifdef ADDR_CALC_FIXPRIO_EN
  localparam bit c_fix = 1'b1;
`else
  localparam bit c_fix = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  addr_calc_sched_if #(.AW(8), .CW(16)) bus ();

  addr_calc_sched #(.AW(8), .CW(16), .BASE(8'h80)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with valids/ptrs already driven; returns at the next IDLE negedge.
  task automatic txn(input logic [7:0] addr, input logic [7:0] bb, input logic exp_src,
                     input logic [15:0] exp_cnt, input string tag);
    bus.address = addr;
    bus.b       = bb;
    #1;
    check({tag, "_rdy0"}, bus.req0_ready, !exp_src);
    check({tag, "_rdy1"}, bus.req1_ready, exp_src);
    @(negedge clk);
    bus.address = ~addr;
    bus.b       = ~bb;
    #1;
    check({tag, "_s1_busy"}, bus.busy, 1);
    check({tag, "_s1_rdy"}, {bus.req0_ready, bus.req1_ready}, 0);
    check({tag, "_s1_oval"}, bus.out_valid, 0);
    @(negedge clk);
    check({tag, "_oval"}, bus.out_valid, 1);
    check({tag, "_count"}, bus.out_count, exp_cnt);
    check({tag, "_src"}, bus.out_src, exp_src);
    @(negedge clk);
    check({tag, "_done_oval"}, bus.out_valid, 0);
  endtask

  initial begin
    n_err          = 0;
    n_chk          = 0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_ptr   = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_ptr   = 8'h00;
    bus.address    = 8'h00;
    bus.b          = 8'h00;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_oval", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.out_count, 0);
    check("rst_src", bus.out_src, 0);
    check("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request and wrap-around cases
    bus.req0_valid = 1'b1;
    bus.req0_ptr   = 8'h10;
    txn(8'h90, 8'h05, 1'b0, 16'h0025, "t1");
    bus.req0_ptr   = 8'h00;
    txn(8'h00, 8'h00, 1'b0, 16'hFF80, "t2a");
    bus.req0_ptr   = 8'hFF;
    txn(8'hFF, 8'hFF, 1'b0, 16'h027D, "t2b");
    bus.req0_valid = 1'b0;

    // contention straight after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_ptr   = 8'h01;
    bus.req1_ptr   = 8'h02;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++)
      txn(8'h80, 8'h00, c_fix ? 1'b1 : i[0], (c_fix || i[0]) ? 16'h0002 : 16'h0001, "t3");
    bus.req1_valid = 1'b0;
    txn(8'h80, 8'h00, 1'b0, 16'h0001, "t3_drop");
    bus.req0_valid = 1'b0;

    // backpressure: req0 was served last, so req1 wins in either build
    bus.req0_ptr   = 8'h77;
    bus.req1_ptr   = 8'h20;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.address    = 8'hA0;
    bus.b          = 8'h03;
    #1;
    check("t4_rdy1", bus.req1_ready, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.address   = 8'h11;
    bus.b         = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.address = bus.address + 8'h13;
      bus.b       = bus.b + 8'h31;
      #1;
      check("t4_oval", bus.out_valid, 1);
      check("t4_count", bus.out_count, 16'h0043);
      check("t4_src", bus.out_src, 1);
      check("t4_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_after_oval", bus.out_valid, 0);
    check("t4_after_rdy0", bus.req0_ready, !c_fix);
    check("t4_after_rdy1", bus.req1_ready, c_fix);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // asynchronous reset while in S1
    bus.req1_ptr   = 8'h11;
    bus.req1_valid = 1'b1;
    #1;
    check("t5_rdy1", bus.req1_ready, 1);
    @(negedge clk);
    #1;
    check("t5_s1_busy", bus.busy, 1);
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_oval", bus.out_valid, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_count", bus.out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_ptr   = 8'h01;
    bus.req1_ptr   = 8'h02;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    txn(8'h80, 8'h00, c_fix, c_fix ? 16'h0002 : 16'h0001, "t5_first");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
